// File: rtl/poly_addmod_seq_pkg.sv
// poly_addmod_seq_pkg: shared RLWE constants, FSM encoding and modulus tables
package poly_addmod_seq_pkg;
  localparam int COEFF_W = 30;
  localparam int NUM_MOD = 8;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  localparam logic [COEFF_W-1:0] Q_S [NUM_MOD] = '{
    30'd1071513601, 30'd1070727169, 30'd1069547521, 30'd1068236801,
    30'd1065484289, 30'd1064697857, 30'd1063321601, 30'd1062469633
  };
  localparam logic [COEFF_W-1:0] Q_L [NUM_MOD] = '{
    30'd1068433409, 30'd1067778049, 30'd1066991617, 30'd1066205185,
    30'd1065156609, 30'd1064370177, 30'd1063583745, 30'd1062797313
  };
  function automatic logic [COEFF_W-1:0] q_of(logic [2:0] idx, logic sel);
    return sel ? Q_L[idx] : Q_S[idx];
  endfunction
endpackage

// File: rtl/poly_addmod_seq_add.sv
// add_mod30bit: registered-input modular adder, c = (a + b) mod q
module add_mod30bit
  import poly_addmod_seq_pkg::*;
#(
  parameter int modular_index = 0
) (
  input  logic               clk,
  input  logic [COEFF_W-1:0] a,
  input  logic [COEFF_W-1:0] b,
  input  logic               modulus_sel,
  output logic [COEFF_W-1:0] c
);
  logic [COEFF_W-1:0] a_q, b_q;
  logic               sel_q;
  logic [COEFF_W:0]   sum, q;
  // operand register sets the one-cycle adder latency
  always_ff @(posedge clk) begin
    a_q   <= a;
    b_q   <= b;
    sel_q <= modulus_sel;
  end
  assign q   = {1'b0, q_of(3'(modular_index), sel_q)};
  assign sum = {1'b0, a_q} + {1'b0, b_q};
  assign c   = sum >= q ? COEFF_W'(sum - q) : sum[COEFF_W-1:0];
endmodule

// File: rtl/poly_addmod_seq.sv
// poly_addmod_seq: sequences c[i] = (a[i] + b[i]) mod q over a coefficient memory
module poly_addmod_seq
  import poly_addmod_seq_pkg::*;
#(
  parameter int MOD_INDEX = 6,
  parameter int ADDR_W    = 12,
  parameter int RD_LAT    = 1,
  parameter int ADD_LAT   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               modulus_sel_in,
  input  logic [ADDR_W:0]    num_coeff,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [COEFF_W-1:0] rd_data_a,
  input  logic [COEFF_W-1:0] rd_data_b,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COEFF_W-1:0] wr_data
);
  localparam int LAT = RD_LAT + ADD_LAT;
  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d, num_q, num_d;
  logic              sel_q, sel_d;
  logic [LAT-1:0]    vld_q, vld_d;
  logic [ADDR_W-1:0] adr_q [LAT];
  assign vld_d   = {vld_q[LAT-2:0], rd_en};
  assign rd_en   = state_q == RUN;
  assign busy    = state_q == RUN || state_q == DRAIN;
  assign done    = state_q == DONE;
  assign rd_addr = cnt_q[ADDR_W-1:0];
  assign wr_en   = vld_q[LAT-1];
  assign wr_addr = adr_q[LAT-1];
  // next state: launch, issue reads on an ADDR_W+1 bit count, drain, pulse done
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: if (start) begin
        num_d   = num_coeff;
        sel_d   = modulus_sel_in;
        cnt_d   = '0;
        state_d = num_coeff == '0 ? DONE : RUN;
      end
      RUN: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_d == num_q ? DRAIN : RUN;
      end
      DRAIN:   state_d = vld_d == '0 ? DONE : DRAIN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state, job registers and the valid/address delay line matching the data path
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      sel_q   <= 1'b0;
      vld_q   <= '0;
      for (int i = 0; i < LAT; i++) adr_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      sel_q    <= sel_d;
      vld_q    <= vld_d;
      adr_q[0] <= rd_addr;
      for (int i = 1; i < LAT; i++) adr_q[i] <= adr_q[i-1];
    end
  end
  add_mod30bit #(.modular_index(MOD_INDEX)) u_add (
    .clk         (clk),
    .a           (rd_data_a),
    .b           (rd_data_b),
    .modulus_sel (sel_q),
    .c           (wr_data)
  );
endmodule
